// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: FSM states,
// exception cause codes and the hardwired-zero register index.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_EXC_DRAIN = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] EXC_NONE        = 2'd0;
    localparam logic [1:0] EXC_BUS_TIMEOUT = 2'd3;
    localparam logic [4:0] REG_ZERO        = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// is a source operand of the instruction in ID (register 0 never hazards).
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_rt,
    input  logic [4:0] IF_ID_rs,
    input  logic [4:0] IF_ID_rt,
    output logic       hazard
);

    logic [9:0] src_regs;
    logic [1:0] src_match;

    assign src_regs = {IF_ID_rt, IF_ID_rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = (src_regs[gi*5 +: 5] == ID_EX_rt);
        end
    endgenerate

    assign hazard = ID_EX_MemRead && (ID_EX_rt != REG_ZERO) && (|src_match);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline registers and PC.
// Optional STALL_CTRL_PERF_CNT_EN adds saturating stall-cycle/exception counters.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_rt,
    input  logic [4:0] IF_ID_rs,
    input  logic [4:0] IF_ID_rt,
    input  logic       Branch_taken,
    input  logic       EX_MEM_MemRead,
    input  logic       EX_MEM_MemWrite,
    input  logic       Mem_ready,
    input  logic [1:0] EX_MEM_ExcCode,
    output logic       PC_Stall,
    output logic       IF_ID_Stall,
    output logic       ID_EX_Stall,
    output logic       EX_MEM_Stall,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_MEM_Flush,
    output logic       MEM_WB_Flush,
    output logic       Exc_redirect,
    output logic [1:0] Exc_cause,
    output logic [1:0] Ctrl_state
`ifdef STALL_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] Perf_stall_cycles,
    output logic [31:0] Perf_exc_count
`endif
);

    localparam bit HAS_DRAIN  = (FLUSH_CYCLES > 1);
    localparam int DRAIN_INIT = HAS_DRAIN ? (FLUSH_CYCLES - 2) : 0;

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;

    logic       hazard;
    logic       eval_hazards;
    logic       take_exc;
    logic [1:0] exc_code;

    load_use_detect u_load_use_detect (
        .ID_EX_MemRead (ID_EX_MemRead),
        .ID_EX_rt      (ID_EX_rt),
        .IF_ID_rs      (IF_ID_rs),
        .IF_ID_rt      (IF_ID_rt),
        .hazard        (hazard)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cause_d      = cause_q;
        eval_hazards = 1'b0;
        take_exc     = 1'b0;
        exc_code     = EXC_NONE;
        PC_Stall     = 1'b0;
        IF_ID_Stall  = 1'b0;
        ID_EX_Stall  = 1'b0;
        EX_MEM_Stall = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        MEM_WB_Flush = 1'b0;
        Exc_redirect = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (EX_MEM_ExcCode != EXC_NONE) begin
                    take_exc = 1'b1;
                    exc_code = EX_MEM_ExcCode;
                end else if ((EX_MEM_MemRead || EX_MEM_MemWrite) && !Mem_ready) begin
                    {PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall} = 4'b1111;
                    MEM_WB_Flush = 1'b1;
                    state_d      = ST_MEM_WAIT;
                    cnt_d        = CNT_W'(1);
                end else begin
                    eval_hazards = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (Mem_ready) begin
                    eval_hazards = 1'b1;
                    state_d      = ST_RUN;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    take_exc = 1'b1;
                    exc_code = EXC_BUS_TIMEOUT;
                end else begin
                    {PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall} = 4'b1111;
                    MEM_WB_Flush = 1'b1;
                    cnt_d        = cnt_q + CNT_W'(1);
                end
            end
            ST_EXC_DRAIN: begin
                {IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush} = 4'b1111;
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        // A taken branch in ID is dropped while the load-use bubble holds it.
        if (eval_hazards) begin
            if (hazard) begin
                PC_Stall    = 1'b1;
                IF_ID_Stall = 1'b1;
                ID_EX_Flush = 1'b1;
            end else if (Branch_taken) begin
                IF_ID_Flush = 1'b1;
            end
        end

        if (take_exc) begin
            Exc_redirect = 1'b1;
            {IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush} = 4'b1111;
            cause_d = exc_code;
            if (HAS_DRAIN) begin
                state_d = ST_EXC_DRAIN;
                cnt_d   = CNT_W'(DRAIN_INIT);
            end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end

        if (reset) begin
            PC_Stall     = 1'b0;
            IF_ID_Stall  = 1'b0;
            ID_EX_Stall  = 1'b0;
            EX_MEM_Stall = 1'b0;
            IF_ID_Flush  = 1'b0;
            ID_EX_Flush  = 1'b0;
            EX_MEM_Flush = 1'b0;
            MEM_WB_Flush = 1'b0;
            Exc_redirect = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            cause_q <= EXC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign Exc_cause  = cause_q;
    assign Ctrl_state = state_q;

`ifdef STALL_CTRL_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_exc_q, perf_exc_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_exc_d   = perf_exc_q;
        if (PC_Stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (Exc_redirect && (perf_exc_q != 32'hFFFF_FFFF)) begin
            perf_exc_d = perf_exc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_exc_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_exc_q   <= perf_exc_d;
        end
    end

    assign Perf_stall_cycles = perf_stall_q;
    assign Perf_exc_count    = perf_exc_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed cases with literal
// expectations, then randomized traffic against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int MEM_TIMEOUT  = 16;
    localparam int FLUSH_CYCLES = 2;

    // Strobe vector order: PC_S, IF_ID_S, ID_EX_S, EX_MEM_S, IF_ID_F, ID_EX_F, EX_MEM_F, MEM_WB_F, redirect
    localparam logic [8:0] S_NONE  = 9'b000000000;
    localparam logic [8:0] S_LU    = 9'b110001000;
    localparam logic [8:0] S_BR    = 9'b000010000;
    localparam logic [8:0] S_MEM   = 9'b111100010;
    localparam logic [8:0] S_EXC   = 9'b000011111;
    localparam logic [8:0] S_DRAIN = 9'b000011110;

    logic       clk = 1'b0;
    logic       reset;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_rt, IF_ID_rs, IF_ID_rt;
    logic       Branch_taken, EX_MEM_MemRead, EX_MEM_MemWrite, Mem_ready;
    logic [1:0] EX_MEM_ExcCode;
    logic       PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall;
    logic       IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush;
    logic       Exc_redirect;
    logic [1:0] Exc_cause, Ctrl_state;
`ifdef STALL_CTRL_PERF_CNT_EN
    logic [31:0] Perf_stall_cycles, Perf_exc_count;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int n_cyc   = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT  (MEM_TIMEOUT),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .ID_EX_rt        (ID_EX_rt),
        .IF_ID_rs        (IF_ID_rs),
        .IF_ID_rt        (IF_ID_rt),
        .Branch_taken    (Branch_taken),
        .EX_MEM_MemRead  (EX_MEM_MemRead),
        .EX_MEM_MemWrite (EX_MEM_MemWrite),
        .Mem_ready       (Mem_ready),
        .EX_MEM_ExcCode  (EX_MEM_ExcCode),
        .PC_Stall        (PC_Stall),
        .IF_ID_Stall     (IF_ID_Stall),
        .ID_EX_Stall     (ID_EX_Stall),
        .EX_MEM_Stall    (EX_MEM_Stall),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Flush     (ID_EX_Flush),
        .EX_MEM_Flush    (EX_MEM_Flush),
        .MEM_WB_Flush    (MEM_WB_Flush),
        .Exc_redirect    (Exc_redirect),
        .Exc_cause       (Exc_cause),
        .Ctrl_state      (Ctrl_state)
`ifdef STALL_CTRL_PERF_CNT_EN
        ,
        .Perf_stall_cycles (Perf_stall_cycles),
        .Perf_exc_count    (Perf_exc_count)
`endif
    );

    // Behavioural model: mode 0=run, 1=waiting on memory, 2=draining.
    bit          m_known = 0;
    int          m_mode = 0, m_stalled = 0, m_drain_left = 0;
    logic [1:0]  m_cause = 2'd0;
    longint      m_perf_stall = 0, m_perf_exc = 0;
    int          n_mode, n_stalled, n_drain_left;
    logic [1:0]  n_cause;
    logic [8:0]  exp_s;

    function automatic logic [8:0] got_strobes();
        return {PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall,
                IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush, Exc_redirect};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, n_cyc);
        end
    endtask

    task automatic model_exception(input logic [1:0] code);
        exp_s   = S_EXC;
        n_cause = code;
        if (FLUSH_CYCLES > 1) begin
            n_mode       = 2;
            n_drain_left = FLUSH_CYCLES - 1;
        end else begin
            n_mode = 0;
        end
    endtask

    task automatic model_eval();
        bit load_use, mem_busy;
        load_use = ID_EX_MemRead && (ID_EX_rt != 0) &&
                   ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
        mem_busy = (EX_MEM_MemRead || EX_MEM_MemWrite) && !Mem_ready;
        exp_s        = S_NONE;
        n_mode       = m_mode;
        n_stalled    = m_stalled;
        n_drain_left = m_drain_left;
        n_cause      = m_cause;
        if (reset) begin
            n_mode = 0; n_stalled = 0; n_drain_left = 0; n_cause = 2'd0;
        end else if (m_mode == 2) begin
            exp_s        = S_DRAIN;
            n_drain_left = m_drain_left - 1;
            if (n_drain_left == 0) n_mode = 0;
        end else if (m_mode == 0 && EX_MEM_ExcCode != 0) begin
            model_exception(EX_MEM_ExcCode);
        end else if (m_mode == 0 && mem_busy) begin
            exp_s = S_MEM; n_mode = 1; n_stalled = 1;
        end else if (m_mode == 1 && !Mem_ready) begin
            if (m_stalled + 1 >= MEM_TIMEOUT) model_exception(2'd3);
            else begin
                exp_s = S_MEM; n_stalled = m_stalled + 1;
            end
        end else begin
            n_mode = 0;
            if (load_use) exp_s = S_LU;
            else if (Branch_taken) exp_s = S_BR;
        end
    endtask

    // Inputs are already applied; check mid-cycle, then advance the model across the edge.
    task automatic tick(input bit has_lit, input logic [8:0] lit);
        model_eval();
        #4;
        chk("strobes", 32'(got_strobes()), 32'(exp_s));
        if (has_lit) chk("strobes_lit", 32'(got_strobes()), 32'(lit));
        if (m_known) begin
            chk("ctrl_state", 32'(Ctrl_state), 32'(m_mode));
            chk("exc_cause", 32'(Exc_cause), 32'(m_cause));
`ifdef STALL_CTRL_PERF_CNT_EN
            chk("perf_stall", Perf_stall_cycles, 32'(m_perf_stall));
            chk("perf_exc", Perf_exc_count, 32'(m_perf_exc));
`endif
        end
        $display("cyc %0d rst=%0b exc=%0d mem=%0b%0b rdy=%0b strobes=%b state=%0d cause=%0d",
                 n_cyc, reset, EX_MEM_ExcCode, EX_MEM_MemRead, EX_MEM_MemWrite,
                 Mem_ready, got_strobes(), Ctrl_state, Exc_cause);
        @(posedge clk);
        if (reset) begin
            m_perf_stall = 0; m_perf_exc = 0; m_known = 1;
        end else begin
            if (exp_s[8] && m_perf_stall < 64'hFFFF_FFFF) m_perf_stall++;
            if (exp_s[0] && m_perf_exc < 64'hFFFF_FFFF) m_perf_exc++;
        end
        m_mode = n_mode; m_stalled = n_stalled; m_drain_left = n_drain_left; m_cause = n_cause;
        n_cyc++;
        #1;
    endtask

    task automatic clr();
        reset = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;
        Branch_taken = 1'b0; EX_MEM_MemRead = 1'b0; EX_MEM_MemWrite = 1'b0;
        Mem_ready = 1'b1; EX_MEM_ExcCode = 2'd0;
    endtask

    task automatic set_load_use();
        ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
    endtask

    int ready_pct;

    initial begin
        clr();
        reset = 1'b1;
        @(posedge clk); #1;
        tick(1, S_NONE);
        tick(1, S_NONE);
        clr();
        tick(1, S_NONE);
        chk("reset_state", 32'(Ctrl_state), 32'd0);
        chk("reset_cause", 32'(Exc_cause), 32'd0);

        // Load-use hazard: one bubble cycle, then nothing once ID moves on.
        set_load_use();
        tick(1, S_LU);
        clr();
        tick(1, S_NONE);
        ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;
        tick(1, S_NONE);
        clr(); Branch_taken = 1'b1;
        tick(1, S_BR);

        // Memory wait of three cycles, released by Mem_ready.
        clr(); EX_MEM_MemRead = 1'b1; Mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1, S_MEM);
            chk("memwait_state", 32'(Ctrl_state), 32'd1);
        end
        Mem_ready = 1'b1;
        tick(1, S_NONE);
        chk("memwait_release_state", 32'(Ctrl_state), 32'd0);

        // Exception beats load-use and branch.
        clr(); EX_MEM_ExcCode = 2'd1; set_load_use(); Branch_taken = 1'b1;
        tick(1, S_EXC);
        chk("exc_cause1", 32'(Exc_cause), 32'd1);
        chk("exc_drain_state", 32'(Ctrl_state), 32'd2);
        tick(1, S_DRAIN);
        chk("exc_after_drain", 32'(Ctrl_state), 32'd0);

        // Bus timeout: exception on the 16th stalled cycle.
        clr(); EX_MEM_MemWrite = 1'b1; Mem_ready = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) tick(1, S_MEM);
        tick(1, S_EXC);
        chk("timeout_cause", 32'(Exc_cause), 32'd3);
        tick(1, S_DRAIN);
        chk("timeout_run", 32'(Ctrl_state), 32'd0);

        // Reset in the middle of a drain.
        clr(); EX_MEM_ExcCode = 2'd2;
        tick(1, S_EXC);
        chk("pre_reset_state", 32'(Ctrl_state), 32'd2);
        reset = 1'b1;
        tick(1, S_NONE);
        chk("reset_drain_state", 32'(Ctrl_state), 32'd0);
        chk("reset_drain_cause", 32'(Exc_cause), 32'd0);
        clr();
        tick(1, S_NONE);

`ifdef STALL_CTRL_PERF_CNT_EN
        reset = 1'b1;
        tick(1, S_NONE);
        clr(); set_load_use();
        for (int i = 0; i < 5; i++) tick(1, S_LU);
        clr(); EX_MEM_ExcCode = 2'd1;
        tick(1, S_EXC);
        clr();
        tick(1, S_DRAIN);
        chk("perf_stall_lit", Perf_stall_cycles, 32'd5);
        chk("perf_exc_lit", Perf_exc_count, 32'd1);
`endif

        // Randomized traffic; Mem_ready density varies per block to reach timeouts.
        ready_pct = 50;
        for (int c = 0; c < 2400; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 3))
                    0: ready_pct = 0;
                    1: ready_pct = 20;
                    2: ready_pct = 50;
                    default: ready_pct = 90;
                endcase
            end
            reset           = ($urandom_range(0, 149) == 0);
            ID_EX_MemRead   = 1'($urandom_range(0, 1));
            ID_EX_rt        = 5'($urandom_range(0, 3));
            IF_ID_rs        = 5'($urandom_range(0, 3));
            IF_ID_rt        = 5'($urandom_range(0, 3));
            Branch_taken    = 1'($urandom_range(0, 1));
            EX_MEM_MemRead  = 1'($urandom_range(0, 1));
            EX_MEM_MemWrite = ($urandom_range(0, 3) == 0);
            Mem_ready       = ($urandom_range(0, 99) < ready_pct);
            EX_MEM_ExcCode  = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            tick(0, S_NONE);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
